neuron_param_loader: RTL and testbench

//  Byte-stream configuration loader directly upstream of the LIF neuron core.

---
 rtl/neuron_cfg_pkg.sv | 25 ++
 rtl/neuron_param_loader.sv | 179 +++++++++++++++++
 tb/tb_neuron_param_loader.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/neuron_cfg_pkg.sv
// rtl/neuron_cfg_pkg.sv - shared opcodes, loader FSM encoding and neuron reset defaults
//
// Purpose: constants shared by the parameter loader and the LIF neuron top.
//   OP_*       header opcodes carried in byte bits [7:6]
//   state_t    loader FSM encoding
//   *_RST      reset values of the neuron parameters; W_RST and TETA_RST
//              are resized to WEIGHTS / OUT_PREC by the user
package neuron_cfg_pkg;

    localparam logic [1:0] OP_ABORT  = 2'b00;
    localparam logic [1:0] OP_WR_W   = 2'b01;
    localparam logic [1:0] OP_WR_TS  = 2'b10;
    localparam logic [1:0] OP_COMMIT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_PAYLOAD     = 2'd1,
        ST_COMMIT_WAIT = 2'd2
    } state_t;

    localparam int W_RST     = 1;
    localparam int SHIFT_RST = 0;
    localparam int TETA_RST  = -5;

endpackage

// File: rtl/neuron_param_loader.sv
// rtl/neuron_param_loader.sv - byte-stream loader committing neuron parameters on the update tick
//
// Purpose: accepts header/payload bytes into a shadow parameter set and copies
// it atomically to the active outputs on the first tick after a COMMIT, so the
// neuron core never sees a half-applied set.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   in_data        command/payload byte
//   in_valid       in_data valid
//   in_ready       byte accepted when in_valid & in_ready (low only while awaiting tick)
//   tick           neuron update strobe, sampled only while a commit is pending
//   w_o            active binary weights (WEIGHTS bits)
//   shift_o        active leak shift
//   minus_teta_o   active negated threshold, two's complement (OUT_PREC bits)
//   pending        commit requested, waiting for tick
//   applied        one-cycle pulse after the edge that updated the active set
//   err            sticky payload-timeout flag, cleared by ABORT
module neuron_param_loader
    import neuron_cfg_pkg::*;
#(
    parameter int N_STAGES = 2,
    parameter int TIMEOUT  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  tick,
    output logic [2**N_STAGES-1:0] w_o,
    output logic [2:0]            shift_o,
    output logic [N_STAGES+1:0]   minus_teta_o,
    output logic                  pending,
    output logic                  applied,
    output logic                  err
);

    localparam int WEIGHTS  = 2**N_STAGES;
    localparam int OUT_PREC = N_STAGES + 2;
    localparam int CW       = $clog2(TIMEOUT);

    localparam logic [WEIGHTS-1:0]  W_INIT     = WEIGHTS'(W_RST);
    localparam logic [2:0]          SHIFT_INIT = 3'(SHIFT_RST);
    localparam logic [OUT_PREC-1:0] TETA_INIT  = OUT_PREC'(TETA_RST);
    localparam logic [CW-1:0]       CNT_LAST   = CW'(TIMEOUT - 1);

    state_t state, state_next;
    logic [CW-1:0] cnt;
    logic          payload_is_ts;

    logic [WEIGHTS-1:0]  shadow_w;
    logic [2:0]          shadow_shift;
    logic [OUT_PREC-1:0] shadow_teta;

    logic       xfer;
    logic [1:0] opcode;
    logic       hdr_payload;
    logic       do_abort;
    logic       do_load;
    logic       do_timeout;
    logic       do_commit;

    // Header bits [5:0] and the payload bits between the field slices carry
    // no meaning; this keeps the whole byte visibly consumed.
    logic unused_in_data;
    assign unused_in_data = ^in_data;

    assign opcode = in_data[7:6];
    assign xfer   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        in_ready    = 1'b1;
        pending     = 1'b0;
        hdr_payload = 1'b0;
        do_abort    = 1'b0;
        do_load     = 1'b0;
        do_timeout  = 1'b0;
        do_commit   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (xfer) begin
                    case (opcode)
                        OP_ABORT:  do_abort = 1'b1;
                        OP_WR_W,
                        OP_WR_TS: begin
                            hdr_payload = 1'b1;
                            state_next  = ST_PAYLOAD;
                        end
                        default:   state_next = ST_COMMIT_WAIT;
                    endcase
                end
            end
            ST_PAYLOAD: begin
                // A byte arriving in the expiry cycle is still taken.
                if (xfer) begin
                    do_load    = 1'b1;
                    state_next = ST_IDLE;
                end else if (cnt == CNT_LAST) begin
                    do_timeout = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_COMMIT_WAIT: begin
                // Only reachable the cycle after the COMMIT header, so a tick
                // coincident with that header never commits.
                in_ready = 1'b0;
                pending  = 1'b1;
                if (tick) begin
                    do_commit  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt           <= '0;
            payload_is_ts <= 1'b0;
            shadow_w      <= W_INIT;
            shadow_shift  <= SHIFT_INIT;
            shadow_teta   <= TETA_INIT;
            w_o           <= W_INIT;
            shift_o       <= SHIFT_INIT;
            minus_teta_o  <= TETA_INIT;
            applied       <= 1'b0;
            err           <= 1'b0;
        end else begin
            // Held at zero outside PAYLOAD, so it starts from zero on entry.
            if (state != ST_PAYLOAD) begin
                cnt <= '0;
            end else if (!xfer) begin
                cnt <= cnt + 1'b1;
            end

            if (hdr_payload) begin
                payload_is_ts <= (opcode == OP_WR_TS);
            end

            if (do_abort) begin
                shadow_w     <= w_o;
                shadow_shift <= shift_o;
                shadow_teta  <= minus_teta_o;
                err          <= 1'b0;
            end

            if (do_load) begin
                if (payload_is_ts) begin
                    shadow_shift <= in_data[7:5];
                    shadow_teta  <= in_data[OUT_PREC-1:0];
                end else begin
                    shadow_w <= in_data[WEIGHTS-1:0];
                end
            end

            if (do_timeout) begin
                err <= 1'b1;
            end

            applied <= do_commit;
            if (do_commit) begin
                w_o          <= shadow_w;
                shift_o      <= shadow_shift;
                minus_teta_o <= shadow_teta;
            end
        end
    end

endmodule

// File: tb/tb_neuron_param_loader.sv
// tb/tb_neuron_param_loader.sv - directed vector bench for neuron_param_loader
module tb_neuron_param_loader;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       tick;
    logic [3:0] w_o;
    logic [2:0] shift_o;
    logic [3:0] minus_teta_o;
    logic       pending;
    logic       applied;
    logic       err;

    neuron_param_loader #(.N_STAGES(2), .TIMEOUT(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .tick         (tick),
        .w_o          (w_o),
        .shift_o      (shift_o),
        .minus_teta_o (minus_teta_o),
        .pending      (pending),
        .applied      (applied),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [7:0]  data;
        logic        tk;
        logic [14:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Packed order: {w_o, shift_o, minus_teta_o, in_ready, pending, applied, err}
    function automatic logic [14:0] ex(input logic [3:0] w, input logic [2:0] sh,
                                       input logic [3:0] t, input logic r,
                                       input logic p, input logic a, input logic e);
        return {w, sh, t, r, p, a, e};
    endfunction

    function automatic void add(input logic r, input logic v, input logic [7:0] d,
                                input logic t, input logic [14:0] e);
        vec_t x;
        x.rst = r; x.vld = v; x.data = d; x.tk = t; x.exp = e;
        tbl.push_back(x);
    endfunction

    task automatic cyc(input logic r, input logic v, input logic [7:0] d, input logic t);
        reset = r; in_valid = v; in_data = d; tick = t;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [14:0] e);
        logic [14:0] act;
        act = {w_o, shift_o, minus_teta_o, in_ready, pending, applied, err};
        n_vec++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s: got w/sh/teta/rdy/pend/app/err=%h/%h/%h/%b%b%b%b expected %h/%h/%h/%b%b%b%b",
                     name, act[14:11], act[10:8], act[7:4], act[3], act[2], act[1], act[0],
                     e[14:11], e[10:8], e[7:4], e[3], e[2], e[1], e[0]);
        end
    endtask

    localparam logic [14:0] RST_IDLE = {4'h1, 3'd0, 4'hB, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; tick = 1'b0;

        // reset state, then a full WR_W / WR_TS / COMMIT with a late tick
        add(1, 0, 8'h00, 0, ex(4'h1, 3'd0, 4'hB, 1, 0, 0, 0));
        add(0, 1, 8'h40, 0, ex(4'h1, 3'd0, 4'hB, 1, 0, 0, 0));
        add(0, 1, 8'h0A, 0, ex(4'h1, 3'd0, 4'hB, 1, 0, 0, 0));
        add(0, 1, 8'h80, 0, ex(4'h1, 3'd0, 4'hB, 1, 0, 0, 0));
        add(0, 1, 8'h63, 0, ex(4'h1, 3'd0, 4'hB, 1, 0, 0, 0));
        add(0, 1, 8'hC0, 0, ex(4'h1, 3'd0, 4'hB, 0, 1, 0, 0));
        for (int i = 0; i < 4; i++)
            add(0, 0, 8'h00, 0, ex(4'h1, 3'd0, 4'hB, 0, 1, 0, 0));
        add(0, 0, 8'h00, 1, ex(4'hA, 3'd3, 4'h3, 1, 0, 1, 0));
        add(0, 0, 8'h00, 0, ex(4'hA, 3'd3, 4'h3, 1, 0, 0, 0));
        // tick coincident with COMMIT acceptance does not commit; bytes refused while pending
        add(0, 1, 8'h40, 0, ex(4'hA, 3'd3, 4'h3, 1, 0, 0, 0));
        add(0, 1, 8'h06, 0, ex(4'hA, 3'd3, 4'h3, 1, 0, 0, 0));
        add(0, 1, 8'hC0, 1, ex(4'hA, 3'd3, 4'h3, 0, 1, 0, 0));
        add(0, 1, 8'h40, 0, ex(4'hA, 3'd3, 4'h3, 0, 1, 0, 0));
        add(0, 0, 8'h00, 1, ex(4'h6, 3'd3, 4'h3, 1, 0, 1, 0));
        add(0, 0, 8'h00, 0, ex(4'h6, 3'd3, 4'h3, 1, 0, 0, 0));
        // ABORT restores shadow from active before COMMIT
        add(1, 0, 8'h00, 0, RST_IDLE);
        add(0, 1, 8'h40, 0, RST_IDLE);
        add(0, 1, 8'h05, 0, RST_IDLE);
        add(0, 1, 8'h00, 0, RST_IDLE);
        add(0, 1, 8'hC0, 0, ex(4'h1, 3'd0, 4'hB, 0, 1, 0, 0));
        add(0, 0, 8'h00, 1, ex(4'h1, 3'd0, 4'hB, 1, 0, 1, 0));
        // tick while idle is ignored
        add(0, 0, 8'h00, 1, RST_IDLE);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].rst, tbl[i].vld, tbl[i].data, tbl[i].tk);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // payload timeout: 15 empty cycles keep waiting, the 16th sets err
        cyc(0, 1, 8'h40, 0);
        for (int i = 0; i < 15; i++) cyc(0, 0, 8'h00, 0);
        check("timeout_not_yet", RST_IDLE);
        cyc(0, 0, 8'h00, 0);
        check("timeout_err", ex(4'h1, 3'd0, 4'hB, 1, 0, 0, 1));
        // back in IDLE: 0xC0 is a COMMIT header, not a payload byte
        cyc(0, 1, 8'hC0, 0);
        check("timeout_idle", ex(4'h1, 3'd0, 4'hB, 0, 1, 0, 1));
        cyc(0, 0, 8'h00, 1);
        check("timeout_shadow_kept", ex(4'h1, 3'd0, 4'hB, 1, 0, 1, 1));
        cyc(0, 1, 8'h00, 0);
        check("abort_clears_err", RST_IDLE);

        // byte arriving in the expiry cycle wins over the timeout
        cyc(0, 1, 8'h40, 0);
        for (int i = 0; i < 15; i++) cyc(0, 0, 8'h00, 0);
        cyc(0, 1, 8'h09, 0);
        check("expiry_xfer_wins", RST_IDLE);
        cyc(0, 1, 8'hC0, 0);
        cyc(0, 0, 8'h00, 1);
        check("expiry_xfer_commit", ex(4'h9, 3'd0, 4'hB, 1, 0, 1, 0));

        // reset while a commit is pending discards it
        cyc(0, 1, 8'h40, 0);
        cyc(0, 1, 8'h03, 0);
        cyc(0, 1, 8'hC0, 0);
        check("pend_before_reset", ex(4'h9, 3'd0, 4'hB, 0, 1, 0, 0));
        cyc(1, 0, 8'h00, 0);
        check("reset_in_wait", RST_IDLE);
        cyc(0, 0, 8'h00, 1);
        check("tick_after_reset_1", RST_IDLE);
        cyc(0, 0, 8'h00, 1);
        check("tick_after_reset_2", RST_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
